// File: rtl/seq_divas_if.sv
// seq_divas_if: start/done handshake and operand/result bus
// between a controller (master) and the sequential divider (slave).
interface seq_divas_if #(
  parameter int W = 4
);
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         dbz;

  modport master (
    output start,
    output dividend,
    output divisor,
    input  busy,
    input  done,
    input  quotient,
    input  remainder,
    input  dbz
  );

  modport slave (
    input  start,
    input  dividend,
    input  divisor,
    output busy,
    output done,
    output quotient,
    output remainder,
    output dbz
  );
endinterface

// File: rtl/seq_divas.sv
// seq_divas: sequential unsigned non-restoring divider.
// One k-controlled add/sub per cycle: P + (D ^ {k}) + k, k = ~sign(P).
module seq_divas #(
  parameter int W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  seq_divas_if.slave bus
);

  localparam int CW = $clog2(W + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  logic [1:0]    r_state;
  logic [W:0]    r_p;
  logic [W-1:0]  r_q;
  logic [W-1:0]  r_d;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;
  logic          r_dbz;
  logic [W-1:0]  r_quo;
  logic [W-1:0]  r_rem;

  logic          w_k;
  logic [W:0]    w_psh;
  logic [W:0]    w_dx;
  logic [W:0]    w_pn;
  logic [W-1:0]  w_qsh;
  logic [W:0]    w_pfix;
  logic          w_dz;
  logic          w_last;

  // one iteration of the shared add/sub step plus the final correction
  always_comb begin
    w_k    = ~r_p[W];
    w_psh  = {r_p[W-1:0], r_q[W-1]};
    w_dx   = {1'b0, r_d} ^ {(W+1){w_k}};
    w_pn   = w_psh + w_dx + {{W{1'b0}}, w_k};
    w_qsh  = {r_q[W-2:0], ~w_pn[W]};
    w_pfix = r_p[W] ? (r_p + {1'b0, r_d}) : r_p;
    w_dz   = (r_d == '0);
    w_last = (r_cnt == CW'(1));
  end

  // control FSM; a zero divisor skips RUN and is resolved in FIX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_busy  <= 1'b1;
            r_state <= (bus.divisor == '0) ? S_FIX : S_RUN;
          end
        end
        S_RUN: begin
          if (w_last) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_FIN;
        end
        S_FIN: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // datapath: operand capture, shift/add-sub iterations, counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p   <= '0;
      r_q   <= '0;
      r_d   <= '0;
      r_cnt <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_q   <= bus.dividend;
            r_d   <= bus.divisor;
            r_p   <= '0;
            r_cnt <= CW'(W);
          end
        end
        S_RUN: begin
          r_p   <= w_pn;
          r_q   <= w_qsh;
          r_cnt <= r_cnt - CW'(1);
        end
        S_FIX: begin
          r_p <= w_pfix;
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  // result registers, written only when an operation completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_quo <= '0;
      r_rem <= '0;
      r_dbz <= 1'b0;
    end else if (r_state == S_FIX) begin
      if (w_dz) begin
        r_quo <= '1;
        r_rem <= r_q;
        r_dbz <= 1'b1;
      end else begin
        r_quo <= r_q;
        r_rem <= w_pfix[W-1:0];
        r_dbz <= 1'b0;
      end
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.quotient  = r_quo;
  assign bus.remainder = r_rem;
  assign bus.dbz       = r_dbz;

endmodule

// File: tb/tb_seq_divas.sv
// tb_seq_divas: directed vectors, multi-cycle corner cases
// and a back-to-back sweep of all W=4 operand pairs.
module tb_seq_divas;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  seq_divas_if #(.W(W)) bus ();

  seq_divas #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int z;
    int lat;
  } vec_t;

  vec_t tv [8];
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // start one op from IDLE; returns results, latency, busy cycles
  task automatic run_div(
    input  int a, input int b,
    output int q, output int r, output int z,
    output int lat, output int nbusy,
    output int busy_d, output int done_after
  );
    bus.dividend = W'(a);
    bus.divisor  = W'(b);
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.dividend = W'(a + 5);
    bus.divisor  = W'(b + 3);
    lat   = 0;
    nbusy = 0;
    while (!bus.done && lat < 30) begin
      if (bus.busy) nbusy++;
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.done) chk("done_timeout", 0, 1);
    q      = int'(bus.quotient);
    r      = int'(bus.remainder);
    z      = int'(bus.dbz);
    busy_d = int'(bus.busy);
    @(posedge clk); #1;
    done_after = int'(bus.done);
  endtask

  initial begin
    int q, r, z, lat, nb, bd, da;
    int ndone, dat, t, ea, eb;

    tv[0] = '{13,  3,  4, 1, 0, 5};
    tv[1] = '{15,  1, 15, 0, 0, 5};
    tv[2] = '{ 7,  9,  0, 7, 0, 5};
    tv[3] = '{ 0,  5,  0, 0, 0, 5};
    tv[4] = '{15, 15,  1, 0, 0, 5};
    tv[5] = '{ 9,  0, 15, 9, 1, 1};
    tv[6] = '{ 6,  4,  1, 2, 0, 5};
    tv[7] = '{12,  5,  2, 2, 0, 5};

    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    #1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_quo",  int'(bus.quotient), 0);
    chk("rst_rem",  int'(bus.remainder), 0);
    chk("rst_dbz",  int'(bus.dbz), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_div(tv[i].a, tv[i].b, q, r, z, lat, nb, bd, da);
      chk($sformatf("v%0d_quo", i), q, tv[i].q);
      chk($sformatf("v%0d_rem", i), r, tv[i].r);
      chk($sformatf("v%0d_dbz", i), z, tv[i].z);
      chk($sformatf("v%0d_lat", i), lat, tv[i].lat);
      chk($sformatf("v%0d_busy_cyc", i), nb, tv[i].lat);
      chk($sformatf("v%0d_busy_at_done", i), bd, 0);
      chk($sformatf("v%0d_done_pulse", i), da, 0);
    end

    // start pulsed mid-RUN must be ignored
    bus.dividend = 4'd13;
    bus.divisor  = 4'd3;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.dividend = 4'd2;
    bus.divisor  = 4'd1;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    ndone = 0;
    dat   = 0;
    q     = 0;
    r     = 0;
    for (int j = 1; j <= 12; j++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        ndone++;
        dat = j;
        q   = int'(bus.quotient);
        r   = int'(bus.remainder);
      end
    end
    chk("midstart_ndone", ndone, 1);
    chk("midstart_when", dat, 2);
    chk("midstart_quo", q, 4);
    chk("midstart_rem", r, 1);

    // asynchronous reset during RUN, after E2
    bus.dividend = 4'd13;
    bus.divisor  = 4'd3;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_busy", int'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_done", int'(bus.done), 0);
    chk("arst_quo",  int'(bus.quotient), 0);
    chk("arst_rem",  int'(bus.remainder), 0);
    chk("arst_dbz",  int'(bus.dbz), 0);
    ndone = 0;
    for (int j = 0; j < 6; j++) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    chk("arst_no_done", ndone, 0);
    rst_n = 1'b1;
    run_div(10, 4, q, r, z, lat, nb, bd, da);
    chk("post_rst_quo", q, 2);
    chk("post_rst_rem", r, 2);
    chk("post_rst_lat", lat, 5);

    // back-to-back sweep, start held high throughout
    bus.dividend = 4'd0;
    bus.divisor  = 4'd0;
    bus.start    = 1'b1;
    for (int i = 0; i < 256; i++) begin
      ea = i / 16;
      eb = i % 16;
      t  = 0;
      while (!bus.done && t < 20) begin
        @(posedge clk); #1;
        t++;
      end
      if (!bus.done) begin
        chk("sweep_timeout", 0, 1);
        break;
      end
      q = (eb == 0) ? 15 : ea / eb;
      r = (eb == 0) ? ea : ea % eb;
      z = (eb == 0) ? 1 : 0;
      chk($sformatf("sw_%0d_%0d_quo", ea, eb), int'(bus.quotient), q);
      chk($sformatf("sw_%0d_%0d_rem", ea, eb), int'(bus.remainder), r);
      chk($sformatf("sw_%0d_%0d_dbz", ea, eb), int'(bus.dbz), z);
      bus.dividend = W'((i + 1) / 16);
      bus.divisor  = W'((i + 1) % 16);
      if (i == 255) bus.start = 1'b0;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    repeat (10) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
